clk_divider_bank: RTL

- Parametrised, runtime-reprogrammable clock-enable and divided-clock generator. It sits downstream of the fixed-frequency PLL wrapper's output clock.
- Produces NUM_CH independent divided clocks plus one-cycle clock-enable strobes.
- Divisors are reprogrammed over a valid/ready config port. Updates are glitch-free: a new divisor is applied only at the channel's count wrap.
- A lock indicator deasserts on reconfiguration and reasserts after a settle interval.

---
 rtl/clk_ctrl_pkg.sv | 30 +++
 rtl/clk_div_channel.sv | 58 +++++
 rtl/clk_divider_bank.sv | 112 +++++++++++
 3 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared helpers for the divided-clock bank: widths, effective divisor, defaults.
// Optional build macro: CLKDIV_SYNC_RESTART_EN (phase-aligned restart on apply).
package clk_ctrl_pkg;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_DIV_W       = 8;
    localparam int DEF_DIV         = 2;
    localparam int DEF_LOCK_CYCLES = 16;

    // Channel-select width, never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Divisors below 2 cannot form a clock, so they run as 2.
    function automatic int unsigned eff_div(input int unsigned d);
        return (d < 2) ? 2 : d;
    endfunction

    // High phase length: ceil(N/2).
    function automatic int unsigned half_div(input int unsigned n);
        return (n + 1) / 2;
    endfunction

    // Lock counter must hold the value LOCK_CYCLES itself.
    function automatic int lock_w(input int c);
        return $clog2(c + 1);
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider slice: counter, divisor, registered outclk and clk_en strobe.
// Optional build macro: CLKDIV_SYNC_RESTART_EN (drives i_clr from the top).
module clk_div_channel
    import clk_ctrl_pkg::*;
#(
    parameter int DIV_W       = DEF_DIV_W,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_clr,
    output logic             o_clk,
    output logic             o_en,
    output logic             o_wrap
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic             r_clk;
    logic             r_en;
    logic [DIV_W-1:0] w_n;
    logic [DIV_W-1:0] w_h;
    logic             w_wrap;

    assign w_n    = DIV_W'(eff_div(32'(r_div)));
    assign w_h    = DIV_W'(half_div(32'(w_n)));
    assign w_wrap = (r_cnt == w_n - DIV_W'(1));

    // Count one period; outputs lag the counter by one cycle, divisor swaps at wrap.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_div <= DIV_W'(DEFAULT_DIV);
            r_clk <= 1'b0;
            r_en  <= 1'b0;
        end else begin
            if (i_clr) begin
                r_cnt <= '0;
                r_clk <= 1'b0;
                r_en  <= 1'b0;
            end else begin
                r_cnt <= w_wrap ? '0 : r_cnt + DIV_W'(1);
                r_clk <= (r_cnt < w_h);
                r_en  <= w_wrap;
            end
            if (i_load) begin
                r_div <= i_div;
            end
        end
    end

    assign o_clk  = r_clk;
    assign o_en   = r_en;
    assign o_wrap = w_wrap;

endmodule

// File: rtl/clk_divider_bank.sv
// Bank of runtime-reprogrammable clock dividers with config slot and lock flag.
// Optional build macro: CLKDIV_SYNC_RESTART_EN (apply at once, restart all phases).
module clk_divider_bank
    import clk_ctrl_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int DIV_W       = DEF_DIV_W,
    parameter int DEFAULT_DIV = DEF_DIV,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic                      refclk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [ch_w(NUM_CH)-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]          cfg_div,
    output logic                      cfg_err,
    output logic [NUM_CH-1:0]         outclk,
    output logic [NUM_CH-1:0]         clk_en,
    output logic                      locked
);

    localparam int CH_W = ch_w(NUM_CH);
    localparam int LW   = lock_w(LOCK_CYCLES);
    localparam logic [CH_W:0] NCH = (CH_W+1)'(NUM_CH);

    logic              r_pend;
    logic [CH_W-1:0]   r_pch;
    logic [DIV_W-1:0]  r_pdiv;
    logic              r_err;
    logic [LW-1:0]     r_lock_cnt;
    logic              r_locked;

    logic              w_accept;
    logic              w_bad;
    logic              w_apply;
    logic              w_clr;
    logic [NUM_CH-1:0] w_sel;
    logic [NUM_CH-1:0] w_wrap;
    logic [NUM_CH-1:0] w_load;

    assign w_accept = cfg_valid && !r_pend;
    assign w_bad    = ({1'b0, cfg_ch} >= NCH);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_sel[i] = r_pend && (r_pch == CH_W'(i));

        clk_div_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .refclk (refclk),
            .rst    (rst),
            .i_load (w_load[i]),
            .i_div  (r_pdiv),
            .i_clr  (w_clr),
            .o_clk  (outclk[i]),
            .o_en   (clk_en[i]),
            .o_wrap (w_wrap[i])
        );
    end

`ifdef CLKDIV_SYNC_RESTART_EN
    assign w_load  = w_sel;
    assign w_apply = r_pend | (|(w_sel & w_wrap));
    assign w_clr   = r_pend;
`else
    assign w_load  = w_sel & w_wrap;
    assign w_apply = |w_load;
    assign w_clr   = 1'b0;
`endif

    // Single pending slot; bad channels are acknowledged and dropped with an error pulse.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            r_pend <= 1'b0;
            r_pch  <= '0;
            r_pdiv <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_accept && w_bad;
            if (w_apply) begin
                r_pend <= 1'b0;
            end else if (w_accept && !w_bad) begin
                r_pend <= 1'b1;
                r_pch  <= cfg_ch;
                r_pdiv <= cfg_div;
            end
        end
    end

    // Settle timer restarts on every apply; locked is sticky until the next apply.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (w_apply) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else begin
            if (r_lock_cnt < LW'(LOCK_CYCLES)) begin
                r_lock_cnt <= r_lock_cnt + LW'(1);
            end
            r_locked <= (r_lock_cnt == LW'(LOCK_CYCLES - 1)) || r_locked;
        end
    end

    assign cfg_ready = !r_pend;
    assign cfg_err   = r_err;
    assign locked    = r_locked;

endmodule
